sync_fifo_level: RTL and testbench

// - Parametrised next-generation single-clock FIFO: binary pointers plus occupancy counter, registered full/empty.
// - Adds programmable almost-full/almost-empty thresholds, a live fill level and optional registered read data.
// - Sits between a producer and consumer on one clock domain; drop-in for flow-controlled streaming buffers.
//

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_level_ram.sv | 29 ++
 rtl/sync_fifo_level.sv | 112 +++++++++++
 tb/tb_sync_fifo_level.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width and depth helpers shared by the FIFO top and its RAM
package sync_fifo_pkg;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int level_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_level_ram.sv
// sync_fifo_level_ram: 1W1R storage array, synchronous write, asynchronous read
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write payload
//   raddr : read address
//   rdata : combinational read payload
module sync_fifo_level_ram
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [depth(ADDR_WIDTH)];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// sync_fifo_level: single-clock FIFO with occupancy counter, thresholds and optional registered read data
//   clk, reset_n               : clock, synchronous active-low reset
//   wen, wdata, wfull          : write side, walmost_full when level >= af_thresh
//   ren, rdata, rvalid, rempty : read side, ralmost_empty when level <= ae_thresh
//   level                      : current occupancy 0..DEPTH
//   af_thresh, ae_thresh       : quasi-static thresholds
//   SYNC_FIFO_LEVEL_ERR_EN     : adds err_clr, sticky overflow/underflow
module sync_fifo_level
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter bit REG_OUT    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh
`ifdef SYNC_FIFO_LEVEL_ERR_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int FIFO_LEVEL_W = level_w(ADDR_WIDTH);
    localparam int PTR_W = ptr_w(ADDR_WIDTH);
    localparam logic [FIFO_LEVEL_W-1:0] DEPTH = FIFO_LEVEL_W'(depth(ADDR_WIDTH));

    logic [PTR_W-1:0]        wbin, rbin;
    logic [FIFO_LEVEL_W-1:0] level_next;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    wincr, rincr;

    assign wincr = wen & ~wfull;
    assign rincr = ren & ~rempty;
    assign level_next = level + FIFO_LEVEL_W'(wincr) - FIFO_LEVEL_W'(rincr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wbin          <= '0;
            rbin          <= '0;
            level         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= (af_thresh == '0);
            ralmost_empty <= 1'b1;
        end else begin
            wbin          <= wbin + PTR_W'(wincr);
            rbin          <= rbin + PTR_W'(rincr);
            level         <= level_next;
            wfull         <= (level_next == DEPTH);
            rempty        <= (level_next == '0);
            walmost_full  <= (level_next >= af_thresh);
            ralmost_empty <= (level_next <= ae_thresh);
        end
    end

    sync_fifo_level_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wincr),
        .waddr(wbin[ADDR_WIDTH-1:0]),
        .wdata(wdata),
        .raddr(rbin[ADDR_WIDTH-1:0]),
        .rdata(ram_rdata)
    );

    generate
        if (REG_OUT) begin : g_reg_out
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rincr;
                    if (rincr) rdata <= ram_rdata;
                end
            end
        end else begin : g_show_ahead
            assign rdata  = ram_rdata;
            assign rvalid = rincr;
        end
    endgenerate

`ifdef SYNC_FIFO_LEVEL_ERR_EN
    // a new error in the same cycle as err_clr stays set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wen & wfull) ? 1'b1 : err_clr ? 1'b0 : overflow;
            underflow <= (ren & rempty) ? 1'b1 : err_clr ? 1'b0 : underflow;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// tb_sync_fifo_level: drives show-ahead and registered-output FIFOs in lockstep against a queue model
module tb_sync_fifo_level;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wen = 1'b0, ren = 1'b0, err_clr = 1'b0;
    logic [7:0] wdata = '0;
    logic [3:0] af_thresh = 4'd6, ae_thresh = 4'd1;

    logic       wfull0, wafull0, rvalid0, rempty0, raempty0;
    logic       wfull1, wafull1, rvalid1, rempty1, raempty1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] level0, level1;
`ifdef SYNC_FIFO_LEVEL_ERR_EN
    logic       ovf0, unf0, ovf1, unf1;
`endif

    always #5 clk = ~clk;

    sync_fifo_level #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .REG_OUT(0)) d0 (
        .clk(clk), .reset_n(reset_n), .wen(wen), .wdata(wdata), .wfull(wfull0),
        .walmost_full(wafull0), .ren(ren), .rdata(rdata0), .rvalid(rvalid0),
        .rempty(rempty0), .ralmost_empty(raempty0), .level(level0),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh)
`ifdef SYNC_FIFO_LEVEL_ERR_EN
        , .err_clr(err_clr), .overflow(ovf0), .underflow(unf0)
`endif
    );

    sync_fifo_level #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .REG_OUT(1)) d1 (
        .clk(clk), .reset_n(reset_n), .wen(wen), .wdata(wdata), .wfull(wfull1),
        .walmost_full(wafull1), .ren(ren), .rdata(rdata1), .rvalid(rvalid1),
        .rempty(rempty1), .ralmost_empty(raempty1), .level(level1),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh)
`ifdef SYNC_FIFO_LEVEL_ERR_EN
        , .err_clr(err_clr), .overflow(ovf1), .underflow(unf1)
`endif
    );

    int         total = 0, passed = 0;
    int         mlevel = 0;
    logic       mov = 1'b0, mun = 1'b0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_state();
        chk("level0", 32'(level0), 32'(mlevel));
        chk("level1", 32'(level1), 32'(mlevel));
        chk("rempty0", 32'(rempty0), 32'(mlevel == 0));
        chk("rempty1", 32'(rempty1), 32'(mlevel == 0));
        chk("wfull0", 32'(wfull0), 32'(mlevel == 8));
        chk("wfull1", 32'(wfull1), 32'(mlevel == 8));
        chk("walmost_full", 32'(wafull0), 32'(mlevel >= 6));
        chk("ralmost_empty", 32'(raempty0), 32'(mlevel <= 1));
`ifdef SYNC_FIFO_LEVEL_ERR_EN
        chk("overflow0", 32'(ovf0), 32'(mov));
        chk("underflow0", 32'(unf0), 32'(mun));
        chk("overflow1", 32'(ovf1), 32'(mov));
        chk("underflow1", 32'(unf1), 32'(mun));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        mlevel = 0;
        mov = 1'b0;
        mun = 1'b0;
        q.delete();
        chk_state();
        chk("rvalid1_rst", 32'(rvalid1), 32'd0);
        chk("rdata1_rst", 32'(rdata1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr);
        logic       acc_w, acc_r;
        logic [7:0] rexp;
        @(negedge clk);
        wen = w;
        wdata = d;
        ren = r;
        err_clr = clr;
        #1;
        acc_r = r && mlevel != 0;
        acc_w = w && mlevel != 8;
        rexp = '0;
        chk("rvalid0", 32'(rvalid0), 32'(acc_r));
        if (acc_r) begin
            rexp = q.pop_front();
            chk("rdata0", 32'(rdata0), 32'(rexp));
        end
        if (acc_w) q.push_back(d);
        mov = (w && mlevel == 8) ? 1'b1 : clr ? 1'b0 : mov;
        mun = (r && mlevel == 0) ? 1'b1 : clr ? 1'b0 : mun;
        mlevel = mlevel + int'(acc_w) - int'(acc_r);
        @(posedge clk);
        #1;
        chk_state();
        chk("rvalid1", 32'(rvalid1), 32'(acc_r));
        if (acc_r) chk("rdata1", 32'(rdata1), 32'(rexp));
    endtask

    initial begin
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hE0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
